// File: rtl/load_store_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// load_store_ctrl_pkg
// Purpose : shared definitions for the load/store controller. Holds the RV32I
//           funct3 width codes, the controller state encoding and small helper
//           functions for legality, alignment, byte enables and store lanes.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package load_store_ctrl_pkg;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
  localparam logic [1:0] ST_RESP_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    ISSUE = ST_ISSUE_ENC,
    RESP  = ST_RESP_ENC
  } lsu_state_e;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

  // Unsigned widths exist only for loads; everything else outside the five
  // codes is illegal.
  function automatic logic f3Legal(input logic [2:0] f3, input logic isStore);
    case (f3)
      F3_B, F3_H, F3_W: f3Legal = 1'b1;
      F3_BU, F3_HU:     f3Legal = !isStore;
      default:          f3Legal = 1'b0;
    endcase
  endfunction

  // The low two funct3 bits give the access size: 00 byte, 01 half, 10 word.
  function automatic logic addrMisaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   addrMisaligned = off[0];
      2'b10:   addrMisaligned = (off != 2'b00);
      default: addrMisaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byteEnable = 4'b0001 << off;
      2'b01:   byteEnable = 4'b0011 << off;
      default: byteEnable = 4'b1111;
    endcase
  endfunction

  // Replicating the low bytes across the word lets memory pick whichever lane
  // the byte enables select without a data shifter.
  function automatic logic [31:0] storeLanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   storeLanes = {4{wdata[7:0]}};
      2'b01:   storeLanes = {2{wdata[15:0]}};
      default: storeLanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_ctrl_load_format.sv
// ---------------------------------------------------------------------------
// lsu_load_format
// Purpose : combinational load formatter. Shifts the addressed lane of the
//           read word down to bit 0, then sign- or zero-extends it by width.
// Ports   : rdata_i  [31:0] raw word from memory
//           offset_i [1:0]  byte offset within the word
//           funct3_i [2:0]  load width/sign code
//           data_o   [31:0] extended load result
// ---------------------------------------------------------------------------
module lsu_load_format
  import load_store_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  // Word loads are always at offset 0, so the shifted word doubles as the
  // word result.
  always_comb begin
    lane   = rdata_i >> {offset_i, 3'b000};
    data_o = lane;
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data_o = {24'b0, lane[7:0]};
      F3_HU:   data_o = {16'b0, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// ---------------------------------------------------------------------------
// load_store_ctrl
// Purpose : sequences one RV32I load/store per request between the MEM stage
//           and a word-wide data memory using a req/ack handshake. Checks
//           width legality and alignment, drives word address, byte enables
//           and replicated store data, formats load data and reports
//           misaligned / fault status with a one-cycle response pulse.
// Ports   : clk_i, rst_i (sync, active-high)
//           req_*  : request in (valid/ready, is_store, funct3, addr, wdata)
//           resp_* : response out (valid pulse, rdata, misaligned, fault)
//           mem_*  : memory side (req, we, addr, be, wdata out; ack, rdata in)
// ---------------------------------------------------------------------------
module load_store_ctrl
  import load_store_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_misaligned_o,
  output logic        resp_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic             isStore_q;
  logic [2:0]       funct3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             misaligned_q;
  logic             fault_q;
  logic [CNT_W-1:0] timeoutCnt_q;

  logic             accept;
  logic             reqLegal;
  logic             reqMisaligned;
  logic             timeoutHit;
  logic [31:0]      loadData;

  assign accept        = (state_q == IDLE) && req_valid_i;
  assign reqLegal      = f3Legal(req_funct3_i, req_is_store_i);
  assign reqMisaligned = addrMisaligned(req_funct3_i[1:0], req_addr_i[1:0]);
  assign timeoutHit    = (timeoutCnt_q == CNT_LAST);

  lsu_load_format u_format (
    .rdata_i  (mem_rdata_i),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (loadData)
  );

  // State register plus the latched request and result. An illegal code
  // reports as a fault only, so the misaligned flag is gated by legality to
  // keep the two status bits exclusive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      isStore_q    <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      rdata_q      <= 32'b0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      timeoutCnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        isStore_q    <= req_is_store_i;
        funct3_q     <= req_funct3_i;
        addr_q       <= req_addr_i;
        wdata_q      <= req_wdata_i;
        rdata_q      <= 32'b0;
        misaligned_q <= reqLegal && reqMisaligned;
        fault_q      <= !reqLegal;
        timeoutCnt_q <= '0;
      end
      if (state_q == ISSUE) begin
        if (mem_ack_i) begin
          rdata_q <= isStore_q ? 32'b0 : loadData;
        end else if (timeoutHit) begin
          fault_q <= 1'b1;
        end else begin
          timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Next state and outputs. Memory-side signals are only driven in ISSUE and
  // response signals only in RESP, so everything idles at zero.
  always_comb begin
    state_d           = state_q;
    req_ready_o       = 1'b0;
    resp_valid_o      = 1'b0;
    resp_rdata_o      = 32'b0;
    resp_misaligned_o = 1'b0;
    resp_fault_o      = 1'b0;
    mem_req_o         = 1'b0;
    mem_we_o          = 1'b0;
    mem_addr_o        = 32'b0;
    mem_be_o          = 4'b0;
    mem_wdata_o       = 32'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d = (!reqLegal || reqMisaligned) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = isStore_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_be_o    = byteEnable(funct3_q[1:0], addr_q[1:0]);
        mem_wdata_o = isStore_q ? storeLanes(funct3_q[1:0], wdata_q) : 32'b0;
        // An ack in the last counted cycle still completes normally.
        if (mem_ack_i || timeoutHit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_o      = 1'b1;
        resp_rdata_o      = rdata_q;
        resp_misaligned_o = misaligned_q;
        resp_fault_o      = fault_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_load_store_ctrl
// Purpose : self-checking bench for load_store_ctrl. Hand-derived vector table,
//           randomized transactions against a behavioural model, and a reset
//           during ISSUE followed by back-to-back store/load.
// ---------------------------------------------------------------------------
module tb_load_store_ctrl;
  import load_store_ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_is_store_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_misaligned_o;
  logic        resp_fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int testsRun = 0;
  int testsFailed = 0;

  load_store_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_is_store_i    (req_is_store_i),
    .req_funct3_i      (req_funct3_i),
    .req_addr_i        (req_addr_i),
    .req_wdata_i       (req_wdata_i),
    .resp_valid_o      (resp_valid_o),
    .resp_rdata_o      (resp_rdata_o),
    .resp_misaligned_o (resp_misaligned_o),
    .resp_fault_o      (resp_fault_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_be_o          (mem_be_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_ack_i         (mem_ack_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // One transaction: request fields, memory behaviour (ackDelay = number of
  // ISSUE cycles before the ack, -1 for never) and the expected observation.
  typedef struct {
    logic        isStore;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackDelay;
    int          expReqCycles;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic        expWe;
    logic [31:0] expWdata;
    int          expRespCycle;
    logic [31:0] expRdata;
    logic        expMis;
    logic        expFault;
  } vec_t;

  vec_t table_q[$];

  function automatic vec_t tv(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int dly,
                              input int reqCyc, input logic [31:0] eAddr, input logic [3:0] eBe,
                              input logic eWe, input logic [31:0] eWd, input int respCyc,
                              input logic [31:0] eRd, input logic eMis, input logic eFault);
    vec_t v;
    v.isStore = st; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rdata = rd; v.ackDelay = dly;
    v.expReqCycles = reqCyc; v.expAddr = eAddr; v.expBe = eBe; v.expWe = eWe;
    v.expWdata = eWd; v.expRespCycle = respCyc; v.expRdata = eRd;
    v.expMis = eMis; v.expFault = eFault;
    return v;
  endfunction

  // Reference model built from the RV32I access rules with plain arithmetic.
  function automatic vec_t modelTxn(input vec_t vin);
    vec_t v = vin;
    int size;
    int off;
    int be;
    bit legal;
    bit signedLd;
    bit served;
    longint unsigned w;
    longint unsigned lim;
    off      = int'(v.addr % 4);
    legal    = (v.f3 inside {3'b000, 3'b001, 3'b010}) ||
               (!v.isStore && (v.f3 inside {3'b100, 3'b101}));
    signedLd = v.f3 inside {3'b000, 3'b001};
    if (v.f3 == 3'b000 || v.f3 == 3'b100)      size = 1;
    else if (v.f3 == 3'b001 || v.f3 == 3'b101) size = 2;
    else                                        size = 4;
    v.expReqCycles = 0; v.expAddr = 0; v.expBe = 0; v.expWe = 0; v.expWdata = 0;
    v.expRespCycle = 1; v.expRdata = 0; v.expMis = 0; v.expFault = 0;
    if (!legal) begin
      v.expFault = 1;
      return v;
    end
    if ((v.addr % size) != 0) begin
      v.expMis = 1;
      return v;
    end
    served         = (v.ackDelay >= 0) && (v.ackDelay < TIMEOUT);
    v.expReqCycles = served ? v.ackDelay + 1 : TIMEOUT;
    v.expRespCycle = v.expReqCycles + 1;
    v.expAddr      = v.addr - (v.addr % 4);
    be             = ((1 << size) - 1) << off;
    v.expBe        = be[3:0];
    v.expFault     = !served;
    if (v.isStore) begin
      v.expWe = 1;
      for (int i = 0; i < 4; i++) v.expWdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
    end else if (served) begin
      lim = 64'd1 << (8 * size);
      w   = (longint'(v.rdata) >> (8 * off)) % lim;
      if (signedLd && w >= lim / 2) w = w + (64'h1_0000_0000 - lim);
      v.expRdata = w[31:0];
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request from IDLE, plays the memory side, and checks the
  // observed interface against the vector's expectations.
  task automatic applyStimulus(input vec_t v, input string tag);
    int          reqCycles = 0;
    int          respCycle = 0;
    bit          gotResp = 0;
    bit          stable = 1;
    logic [31:0] oAddr = 0, oWdata = 0, oRdata = 0;
    logic [3:0]  oBe = 0;
    logic        oWe = 0, oMis = 0, oFault = 0;
    @(negedge clk_i);
    checkOutput({tag, " ready"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i    = 1'b1;
    req_is_store_i = v.isStore;
    req_funct3_i   = v.f3;
    req_addr_i     = v.addr;
    req_wdata_i    = v.wdata;
    mem_rdata_i    = ~v.rdata;
    for (int c = 1; c <= 40 && !gotResp; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = ~v.rdata;
      if (mem_req_o) begin
        if (reqCycles == 0) begin
          oAddr = mem_addr_o; oBe = mem_be_o; oWe = mem_we_o; oWdata = mem_wdata_o;
        end else if (oAddr !== mem_addr_o || oBe !== mem_be_o || oWe !== mem_we_o ||
                     oWdata !== mem_wdata_o) begin
          stable = 0;
        end
        if (v.ackDelay == reqCycles) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = v.rdata;
        end
        reqCycles++;
      end
      if (resp_valid_o) begin
        gotResp = 1; respCycle = c;
        oRdata = resp_rdata_o; oMis = resp_misaligned_o; oFault = resp_fault_o;
      end
    end
    checkOutput({tag, " resp seen"}, {31'b0, gotResp}, 32'd1);
    checkOutput({tag, " mem_req cycles"}, reqCycles, v.expReqCycles);
    if (v.expReqCycles > 0) begin
      checkOutput({tag, " mem_addr"}, oAddr, v.expAddr);
      checkOutput({tag, " mem_be"}, {28'b0, oBe}, {28'b0, v.expBe});
      checkOutput({tag, " mem_we"}, {31'b0, oWe}, {31'b0, v.expWe});
      checkOutput({tag, " mem_wdata"}, oWdata, v.expWdata);
      checkOutput({tag, " mem stable"}, {31'b0, stable}, 32'd1);
    end
    checkOutput({tag, " resp cycle"}, respCycle, v.expRespCycle);
    checkOutput({tag, " resp_rdata"}, oRdata, v.expRdata);
    checkOutput({tag, " misaligned"}, {31'b0, oMis}, {31'b0, v.expMis});
    checkOutput({tag, " fault"}, {31'b0, oFault}, {31'b0, v.expFault});
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    checkOutput({tag, " single pulse"}, {31'b0, resp_valid_o}, 32'd0);
    checkOutput({tag, " ready after"}, {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    rst_i = 1'b1; req_valid_i = 1'b0; req_is_store_i = 1'b0; req_funct3_i = 3'b000;
    req_addr_i = 32'b0; req_wdata_i = 32'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    checkOutput("reset ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("reset mem_req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("reset resp_valid", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("reset mem_addr", mem_addr_o, 32'd0);
    checkOutput("reset mem_be/we", {27'b0, mem_be_o, mem_we_o}, 32'd0);
    checkOutput("reset flags", {30'b0, resp_misaligned_o, resp_fault_o}, 32'd0);
    rst_i = 1'b0;

    // Hand-derived vectors
    table_q.push_back(tv(0, F3_B,  32'h103, 0, 32'h80AABBCC, 2, 3, 32'h100, 4'b1000, 0, 0, 4, 32'hFFFFFF80, 0, 0));
    table_q.push_back(tv(0, F3_BU, 32'h103, 0, 32'h80AABBCC, 2, 3, 32'h100, 4'b1000, 0, 0, 4, 32'h00000080, 0, 0));
    table_q.push_back(tv(0, F3_H,  32'h102, 0, 32'h80AABBCC, 2, 3, 32'h100, 4'b1100, 0, 0, 4, 32'hFFFF80AA, 0, 0));
    table_q.push_back(tv(0, F3_HU, 32'h102, 0, 32'h80AABBCC, 2, 3, 32'h100, 4'b1100, 0, 0, 4, 32'h000080AA, 0, 0));
    table_q.push_back(tv(1, F3_H,  32'h202, 32'h1234ABCD, 32'hDEADBEEF, 0, 1, 32'h200, 4'b1100, 1, 32'hABCDABCD, 2, 0, 0, 0));
    table_q.push_back(tv(0, F3_W,  32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    table_q.push_back(tv(1, F3_BU, 32'h040, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    table_q.push_back(tv(0, F3_W,  32'h300, 0, 32'h11111111, -1, 16, 32'h300, 4'b1111, 0, 0, 17, 0, 0, 1));
    table_q.push_back(tv(0, F3_W,  32'h400, 0, 32'h13579BDF, 15, 16, 32'h400, 4'b1111, 0, 0, 17, 32'h13579BDF, 0, 0));
    table_q.push_back(tv(1, F3_W,  32'h700, 32'h1, 0, 16, 16, 32'h700, 4'b1111, 1, 32'h1, 17, 0, 0, 1));
    table_q.push_back(tv(1, F3_B,  32'h005, 32'h000000A5, 0, 1, 2, 32'h004, 4'b0010, 1, 32'hA5A5A5A5, 3, 0, 0, 0));
    table_q.push_back(tv(0, F3_H,  32'h001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    table_q.push_back(tv(0, F3_HU, 32'h203, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    table_q.push_back(tv(0, 3'b011, 32'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    table_q.push_back(tv(0, 3'b110, 32'h008, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    table_q.push_back(tv(1, F3_W,  32'h010, 32'hCAFEF00D, 0, 0, 1, 32'h010, 4'b1111, 1, 32'hCAFEF00D, 2, 0, 0, 0));
    table_q.push_back(tv(0, F3_B,  32'h000, 0, 32'h1234567F, 3, 4, 32'h000, 4'b0001, 0, 0, 5, 32'h0000007F, 0, 0));
    for (int i = 0; i < table_q.size(); i++) begin
      applyStimulus(table_q[i], $sformatf("vec%0d", i));
    end

    // Reset during ISSUE, then a late ack while IDLE must be ignored
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_store_i = 1'b0; req_funct3_i = F3_W; req_addr_i = 32'h500;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("rstseq issue", {31'b0, mem_req_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rstseq mem_req dropped", {31'b0, mem_req_o}, 32'd0);
    checkOutput("rstseq ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("rstseq no resp", {31'b0, resp_valid_o}, 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBADBAD00;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    checkOutput("late ack no resp", {31'b0, resp_valid_o}, 32'd0);
    checkOutput("late ack no mem_req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("late ack ready", {31'b0, req_ready_o}, 32'd1);

    // Back-to-back store then load after the reset
    v = tv(1, F3_W, 32'h600, 32'h0BADF00D, 32'h0, 1, 2, 32'h600, 4'b1111, 1, 32'h0BADF00D, 3, 0, 0, 0);
    applyStimulus(v, "b2b SW");
    v = tv(0, F3_W, 32'h600, 0, 32'h0BADF00D, 0, 1, 32'h600, 4'b1111, 0, 0, 2, 32'h0BADF00D, 0, 0);
    applyStimulus(v, "b2b LW");

    // Randomized transactions against the reference model
    for (int n = 0; n < 150; n++) begin
      v.isStore = 1'($urandom_range(0, 1));
      v.f3      = 3'($urandom_range(0, 7));
      v.addr    = $urandom();
      v.wdata   = $urandom();
      v.rdata   = $urandom();
      case ($urandom_range(0, 9))
        0:       v.ackDelay = -1;
        1:       v.ackDelay = TIMEOUT - 1;
        2:       v.ackDelay = TIMEOUT;
        default: v.ackDelay = int'($urandom_range(0, 5));
      endcase
      if (n % 3 != 0) v.f3 = {1'b0, 2'($urandom_range(0, 2))};
      if (n % 4 != 0) v.addr[1:0] = 2'b00;
      applyStimulus(modelTxn(v), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
